// File: rtl/ram_loader_pkg.sv
// Shared types and defaults for the RAM byte loader.
// Imported by the loader top and its byte packer.
package ram_loader_pkg;

  localparam int ADDR_WIDTH_DEF = 16;
  localparam int LEN_WIDTH_DEF  = 18;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/ram_byte_loader_if.sv
// Byte stream input plus Avalon-MM write port toward the RAM.
// master = loader side, slave = source/RAM side.
interface ram_byte_loader_if #(
  parameter int ADDR_WIDTH = 16
);

  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  ram_chipselect;
  logic                  ram_write;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [3:0]            ram_byteenable;
  logic [31:0]           ram_writedata;

  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output ram_chipselect,
    output ram_write,
    output ram_address,
    output ram_byteenable,
    output ram_writedata
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  ram_chipselect,
    input  ram_write,
    input  ram_address,
    input  ram_byteenable,
    input  ram_writedata
  );

endinterface

// File: rtl/ram_byte_loader_byte_packer.sv
// Little-endian byte-to-word packer with per-lane enables.
// data_nxt/be_nxt include a byte being pushed this cycle.
module byte_packer
  import ram_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  byte_in,
  output logic        last_lane,
  output logic [31:0] data_nxt,
  output logic [3:0]  be_nxt
);

  logic [1:0]  lane_idx;
  logic [31:0] data_q;
  logic [3:0]  be_q;

  assign last_lane =
    (lane_idx == 2'(BYTES_PER_WORD - 1));

  always_comb begin
    data_nxt = data_q;
    be_nxt   = be_q;
    if (push) begin
      data_nxt[{lane_idx, 3'b000} +: 8] = byte_in;
      be_nxt[lane_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      lane_idx <= '0;
      data_q   <= '0;
      be_q     <= '0;
    end else if (push) begin
      lane_idx <= lane_idx + 2'd1;
      data_q   <= data_nxt;
      be_q     <= be_nxt;
    end
  end

endmodule

// File: rtl/ram_byte_loader.sv
// Packs a byte stream into 32-bit words and writes them to RAM.
// Outputs are registered from next-state; in_ready decodes state.
module ram_byte_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  byte_len,
  ram_byte_loader_if.master     bus,
  output logic                  busy,
  output logic                  done
);

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic                  accept;
  logic                  cmd;
  logic                  clear;
  logic                  last_lane;
  logic [31:0]           data_nxt;
  logic [3:0]            be_nxt;

  assign bus.in_ready = (state_q == FILL);
  assign accept = bus.in_valid && bus.in_ready;
  assign cmd    = (state_q == IDLE) && start;
  assign clear  = cmd || (state_q == WRITE);

  byte_packer u_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .push      (accept),
    .byte_in   (bus.in_data),
    .last_lane (last_lane),
    .data_nxt  (data_nxt),
    .be_nxt    (be_nxt)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (start)
          state_d = (byte_len != '0) ? FILL : DONE;
      FILL:
        if (accept &&
            (last_lane || rem_q == LEN_WIDTH'(1)))
          state_d = WRITE;
      WRITE:
        state_d = (rem_q != '0) ? FILL : DONE;
      DONE:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q            <= IDLE;
      addr_q             <= '0;
      rem_q              <= '0;
      bus.ram_chipselect <= 1'b0;
      bus.ram_write      <= 1'b0;
      bus.ram_address    <= '0;
      bus.ram_byteenable <= '0;
      bus.ram_writedata  <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cmd) begin
        addr_q <= start_addr;
        rem_q  <= byte_len;
      end
      if (accept)
        rem_q <= rem_q - LEN_WIDTH'(1);
      // wraps modulo 2^ADDR_WIDTH
      if (state_q == WRITE)
        addr_q <= addr_q + ADDR_WIDTH'(1);
      bus.ram_chipselect <= (state_d == WRITE);
      bus.ram_write      <= (state_d == WRITE);
      if (state_q == FILL && state_d == WRITE) begin
        bus.ram_address    <= addr_q;
        bus.ram_byteenable <= be_nxt;
        bus.ram_writedata  <= data_nxt;
      end
      busy <= (state_d != IDLE);
      done <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_ram_byte_loader.sv
// Scoreboard bench: tasks push expected RAM writes,
// a negedge monitor pops and compares them.
module tb_ram_byte_loader;

  typedef struct packed {
    logic [15:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } wr_t;

  logic        clk = 0;
  logic        reset_n = 0;
  logic        start = 0;
  logic [15:0] start_addr = '0;
  logic [17:0] byte_len = '0;
  logic        busy;
  logic        done;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_wr = 0;
  int wr_in_cmd = 0;
  int done_cnt = 0;

  wr_t exp_q[$];

  ram_byte_loader_if #(.ADDR_WIDTH(16)) bus ();

  ram_byte_loader #(
    .ADDR_WIDTH(16),
    .LEN_WIDTH (18)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .start_addr(start_addr),
    .byte_len  (byte_len),
    .bus       (bus.slave),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (reset_n && bus.ram_write) begin
      wr_t got;
      wr_t want;
      got = '{bus.ram_address,
              bus.ram_byteenable,
              bus.ram_writedata};
      check("ready_in_write", 64'(bus.in_ready), 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(got), 64'd0);
      end else begin
        want = exp_q.pop_front();
        check("ram_write", 64'(got), 64'(want));
      end
      last_wr = cyc;
      wr_in_cmd++;
    end
    if (reset_n && done) begin
      done_cnt++;
      check("busy_at_done", 64'(busy), 64'd1);
      check("writes_left_at_done",
            64'(exp_q.size()), 64'd0);
      if (wr_in_cmd > 0)
        check("done_after_write",
              64'(cyc - last_wr), 64'd1);
      wr_in_cmd = 0;
    end
  end

  task automatic pulse_start(input logic [15:0] a,
                             input logic [17:0] len);
    start_addr = a;
    byte_len   = len;
    start      = 1;
    @(posedge clk); #1;
    start      = 0;
    check("busy_T1", 64'(busy), 64'd1);
    check("ready_T1", 64'(bus.in_ready),
          64'(len != 0));
  endtask

  task automatic send(input logic [7:0] b,
                      input bit gappy);
    bit r;
    bit ok;
    if (gappy && $urandom_range(0, 1) == 1) begin
      bus.in_valid = 0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1;
    bus.in_data  = b;
    ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      r = bus.in_ready;
      @(posedge clk); #1;
      if (r) ok = 1;
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
    bus.in_valid = 0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) begin
      check("done_timeout", 64'd0, 64'd1);
    end else begin
      @(negedge clk);
      check("busy_after_done", 64'(busy), 64'd0);
      check("done_one_cycle", 64'(done), 64'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_cmd(input logic [15:0] a,
                         input logic [17:0] len,
                         input logic [7:0] v [12],
                         input bit gappy);
    pulse_start(a, len);
    for (int i = 0; i < int'(len); i++)
      send(v[i], gappy);
    wait_done();
  endtask

  task automatic check_reset_outs(input string nm);
    check({nm, "_ready"}, 64'(bus.in_ready), 64'd0);
    check({nm, "_cs"}, 64'(bus.ram_chipselect), 64'd0);
    check({nm, "_wr"}, 64'(bus.ram_write), 64'd0);
    check({nm, "_addr"}, 64'(bus.ram_address), 64'd0);
    check({nm, "_be"}, 64'(bus.ram_byteenable), 64'd0);
    check({nm, "_wdata"}, 64'(bus.ram_writedata), 64'd0);
    check({nm, "_busy"}, 64'(busy), 64'd0);
    check({nm, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [7:0] v [12];
    int dn;
    bus.in_valid = 0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("reset");
    reset_n = 1;
    @(posedge clk); #1;

    // two full words
    v = '{8'h11, 8'h22, 8'h33, 8'h44,
          8'h55, 8'h66, 8'h77, 8'h88,
          8'h00, 8'h00, 8'h00, 8'h00};
    exp_q.push_back('{16'h0010, 4'hF, 32'h44332211});
    exp_q.push_back('{16'h0011, 4'hF, 32'h88776655});
    run_cmd(16'h0010, 18'd8, v, 0);

    // partial final word
    v = '{8'hA0, 8'hA1, 8'hA2, 8'hA3,
          8'hA4, 8'hA5, 8'h00, 8'h00,
          8'h00, 8'h00, 8'h00, 8'h00};
    exp_q.push_back('{16'h0100, 4'hF, 32'hA3A2A1A0});
    exp_q.push_back('{16'h0101, 4'h3, 32'h0000A5A4});
    run_cmd(16'h0100, 18'd6, v, 0);

    // address wrap
    v = '{8'h01, 8'h02, 8'h03, 8'h04,
          8'h05, 8'h06, 8'h07, 8'h08,
          8'h00, 8'h00, 8'h00, 8'h00};
    exp_q.push_back('{16'hFFFF, 4'hF, 32'h04030201});
    exp_q.push_back('{16'h0000, 4'hF, 32'h08070605});
    run_cmd(16'hFFFF, 18'd8, v, 0);

    // zero length
    pulse_start(16'h0040, 18'd0);
    dn = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("ready_zero_len", 64'(bus.in_ready), 64'd0);
      if (done) dn++;
    end
    check("done_zero_len", 64'(dn), 64'd1);
    @(posedge clk); #1;

    // gappy stream, 12 bytes
    v = '{8'h01, 8'h02, 8'h03, 8'h04,
          8'h05, 8'h06, 8'h07, 8'h08,
          8'h09, 8'h0A, 8'h0B, 8'h0C};
    exp_q.push_back('{16'h0200, 4'hF, 32'h04030201});
    exp_q.push_back('{16'h0201, 4'hF, 32'h08070605});
    exp_q.push_back('{16'h0202, 4'hF, 32'h0C0B0A09});
    run_cmd(16'h0200, 18'd12, v, 1);

    // reset after 2 of 4 bytes
    pulse_start(16'h0020, 18'd4);
    send(8'h5A, 0);
    send(8'h6B, 0);
    reset_n = 0;
    @(posedge clk); #1;
    check_reset_outs("midreset");
    @(posedge clk); #1;
    reset_n = 1;
    @(posedge clk); #1;

    v = '{8'hDE, 8'hAD, 8'hBE, 8'hEF,
          8'h00, 8'h00, 8'h00, 8'h00,
          8'h00, 8'h00, 8'h00, 8'h00};
    exp_q.push_back('{16'h0030, 4'hF, 32'hEFBEADDE});
    run_cmd(16'h0030, 18'd4, v, 0);

    repeat (3) @(posedge clk);
    #1;
    check("done_count", 64'(done_cnt), 64'd6);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
